single_arb: RTL

SINGLE_ARB -- requirements
Module: single_arb

---
 rtl/single_arb.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/single_arb.sv
// Round-robin stub arbiter over NCH chamber inputs, with per-orbit rate masking
// of noisy chambers and a bc0-driven orbit synchroniser.
module single_arb #(
  parameter int NCH       = 45,
  parameter int BW_PH     = 13,
  parameter int BW_TH     = 7,
  parameter int ORBIT_LEN = 3564,
  parameter int RATE_MAX  = 16,
  parameter int CNT_W     = 12
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        bc0,
  input  logic [NCH-1:0]              vl,
  input  logic [NCH-1:0][BW_PH-1:0]   ph,
  input  logic [NCH-1:0][BW_TH-1:0]   th,
  output logic                        vl_out,
  output logic [BW_PH-1:0]            ph_out,
  output logic [BW_TH-1:0]            th_out,
  output logic [5:0]                  ch_out,
  output logic [NCH-1:0]              link_good,
  output logic [5:0]                  n_masked,
  output logic                        synced,
  output logic                        sync_err
);

  localparam int OW = (ORBIT_LEN > 1) ? $clog2(ORBIT_LEN) : 1;
  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [OW-1:0]    ORBIT_LAST = OW'(ORBIT_LEN - 1);
  localparam logic [PW-1:0]    PTR_LAST   = PW'(NCH - 1);
  localparam logic [CNT_W:0]   RATE_LIM   = (CNT_W + 1)'(RATE_MAX);

  typedef enum logic {SYNC, RUN} state_t;

  state_t            state_q, state_d;
  logic [OW-1:0]     orbit_q;
  logic [CNT_W-1:0]  rate_q [NCH];
  logic [PW-1:0]     ptr_q;
  logic              orbit_last;
  logic              oe;
  logic [NCH-1:0]    hit;
  logic [NCH-1:0]    keep;
  logic [NCH-1:0]    elig;
  logic [NCH-1:0]    above;
  logic [NCH-1:0]    pick;
  logic              found;
  logic [PW-1:0]     grant;
  logic [5:0]        zeros;

  // ---------------------------------------------------------------- sync FSM
  // NOTE: every sequential block uses non-blocking assignments so all
  // registers sample pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= SYNC;
    else     state_q <= state_d;
  end

  // NOTE: each always_comb assigns its outputs a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SYNC:    if (bc0) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = SYNC;
    endcase
  end

  assign synced     = (state_q == RUN);
  assign orbit_last = (orbit_q == ORBIT_LAST);
  assign oe         = synced && (orbit_last || bc0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     orbit_q <= '0;
    else if (bc0 || orbit_last)  orbit_q <= '0;
    else                         orbit_q <= orbit_q + OW'(1);
  end

  // A bc0 that does not land on the last BX means the orbit count drifted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              sync_err <= 1'b0;
    else if (synced && bc0 && !orbit_last) sync_err <= 1'b1;
  end

  // ---------------------------------------------------------------- rate mask
  assign hit = en ? vl : '0;

  always_comb begin
    keep = '0;
    for (int c = 0; c < NCH; c++)
      keep[c] = ({1'b0, rate_q[c]} + (CNT_W + 1)'(hit[c])) < RATE_LIM;
  end

  // NOTE: the rate array is reset explicitly because a mid-orbit reset must
  // discard partial counts; it is a register bank, not a RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) rate_q[c] <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (!synced || oe)                 rate_q[c] <= '0;
        else if (hit[c] && rate_q[c] != '1) rate_q[c] <= rate_q[c] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     link_good <= '1;
    else if (oe) link_good <= keep;
  end

  always_comb begin
    zeros = '0;
    for (int c = 0; c < NCH; c++) zeros = zeros + 6'(!link_good[c]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) n_masked <= '0;
    else     n_masked <= zeros;
  end

  // ---------------------------------------------------------------- round robin
  assign elig  = hit & link_good;
  assign found = |elig;

  // Prefer the lowest eligible index at or above ptr, else wrap to the lowest overall.
  always_comb begin
    above = '0;
    for (int i = 0; i < NCH; i++) above[i] = elig[i] && (i >= int'(ptr_q));
    pick  = (|above) ? above : elig;
    grant = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if (pick[i]) grant = PW'(i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        ptr_q <= '0;
    else if (found) ptr_q <= (grant == PTR_LAST) ? '0 : grant + PW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vl_out <= 1'b0;
      ph_out <= '0;
      th_out <= '0;
      ch_out <= '0;
    end else if (found) begin
      vl_out <= 1'b1;
      ph_out <= ph[grant];
      th_out <= th[grant];
      ch_out <= 6'(grant);
    end else begin
      vl_out <= 1'b0;
      ph_out <= '0;
      th_out <= '0;
      ch_out <= '0;
    end
  end

endmodule
